// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: state encoding, the default
// source count and the fixed-priority encoder.
package irq_pkg;

    localparam int N_SRC_DEF = 4;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] REQ     = 2'b01;
    localparam logic [1:0] SERVICE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = IDLE,
        ST_REQ     = REQ,
        ST_SERVICE = SERVICE
    } irq_state_e;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [3:0] prio_enc(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Request/acknowledge handshake between the interrupt controller (master)
// and the pipeline trap logic (slave).
interface irq_ctrl_if #(
    parameter int ID_W = $clog2(irq_pkg::N_SRC_DEF)
);
    logic            irq_req;
    logic [ID_W-1:0] irq_id;
    logic            trap_we;
    logic            in_service;
    logic            irq_ack;
    logic            eret;

    modport master (
        output irq_req, irq_id, trap_we, in_service,
        input  irq_ack, eret
    );

    modport slave (
        input  irq_req, irq_id, trap_we, in_service,
        output irq_ack, eret
    );
endinterface

// File: rtl/irq_pend_bit.sv
// One interrupt source: rising-edge detector feeding a pending flop in which
// a new event beats a same-cycle clear.
module irq_pend_bit (
    input  logic clk,
    input  logic clrn,
    input  logic src,
    input  logic clr,
    output logic pend
);
    logic src_q_r;
    logic pend_r;
    logic rise_s;

    assign rise_s = src & ~src_q_r;
    assign pend   = pend_r;

    // Sample history and pending state; set has priority over clear.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            src_q_r <= 1'b0;
            pend_r  <= 1'b0;
        end else begin
            src_q_r <= src;
            if (rise_s) begin
                pend_r <= 1'b1;
            end else if (clr) begin
                pend_r <= 1'b0;
            end else begin
                pend_r <= pend_r;
            end
        end
    end
endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller top: mask register, fixed-priority arbitration and the
// IDLE/REQ/SERVICE handshake FSM, one interrupt in service at a time.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int ID_W  = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_d,
    input  logic             ie,
    irq_ctrl_if.master       bus,
    output logic [N_SRC-1:0] pending,
    output logic [N_SRC-1:0] mask
);
    irq_state_e      state_r;
    irq_state_e      state_s;
    logic [N_SRC-1:0] mask_r;
    logic [N_SRC-1:0] eligible_s;
    logic [N_SRC-1:0] clr_s;
    logic [ID_W-1:0]  irq_id_r;
    logic [ID_W-1:0]  id_s;
    logic [ID_W-1:0]  winner_s;
    logic             irq_req_r;
    logic             in_service_r;
    logic             trap_we_s;

    assign eligible_s = pending & mask_r & {N_SRC{ie}};
    assign winner_s   = ID_W'(prio_enc(16'(eligible_s)));
    assign trap_we_s  = bus.irq_ack & irq_req_r;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        assign clr_s[g] = trap_we_s & (irq_id_r == ID_W'(g));

        irq_pend_bit u_pend (
            .clk  (clk),
            .clrn (clrn),
            .src  (irq_src[g]),
            .clr  (clr_s[g]),
            .pend (pending[g])
        );
    end

    // Mask register; reset leaves every source masked.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mask_r <= {N_SRC{1'b0}};
        end else if (mask_we) begin
            mask_r <= mask_d;
        end else begin
            mask_r <= mask_r;
        end
    end

    // Next state and ID latch; an outstanding request keeps its ID even if a
    // higher-priority source arrives.
    always_comb begin
        state_s = state_r;
        id_s    = irq_id_r;
        case (state_r)
            ST_IDLE: begin
                if (|eligible_s) begin
                    state_s = ST_REQ;
                    id_s    = winner_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.irq_ack) begin
                    state_s = ST_SERVICE;
                end else if (!ie || !mask_r[irq_id_r]) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_SERVICE: begin
                if (bus.eret) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SERVICE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered handshake outputs.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_r      <= ST_IDLE;
            irq_id_r     <= {ID_W{1'b0}};
            irq_req_r    <= 1'b0;
            in_service_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            irq_id_r     <= id_s;
            irq_req_r    <= (state_s == ST_REQ);
            in_service_r <= (state_s == ST_SERVICE);
        end
    end

    assign bus.irq_req    = irq_req_r;
    assign bus.irq_id     = irq_id_r;
    assign bus.in_service = in_service_r;
    assign bus.trap_we    = trap_we_s;
    assign mask           = mask_r;
endmodule
